// File: rtl/cpu_pkg.sv
// Shared BasicCPU datapath constants and sizing helpers.
package cpu_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    // Select width for a SIZE-input selector; never narrower than one bit.
    function automatic int sel_width(input int size);
        return (size <= 2) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/mux_switch_reg_if.sv
// Bus bundle for mux_switch_reg: bit-mux data, packed switch words, shared
// select and the two registered results.
interface mux_switch_reg_if import cpu_pkg::*; #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();
    localparam int SEL_WIDTH = sel_width(SIZE);

    logic [SIZE-1:0]            D;
    logic [SIZE*DATA_WIDTH-1:0] data_in;
    logic [SEL_WIDTH-1:0]       S;
    logic                       Y;
    logic [DATA_WIDTH-1:0]      data_out;

    modport master (output D, data_in, S, input  Y, data_out);
    modport slave  (input  D, data_in, S, output Y, data_out);
endinterface

// File: rtl/mux_switch_reg_word_select.sv
// Combinational slice picker: returns word `sel` of a packed SIZE*WIDTH bus,
// or zero when sel >= SIZE (only reachable for non-power-of-two SIZE).
module word_select import cpu_pkg::*; #(
    parameter int SIZE  = 8,
    parameter int WIDTH = 1
) (
    input  logic [SIZE*WIDTH-1:0]     bus,
    input  logic [sel_width(SIZE)-1:0] sel,
    output logic [WIDTH-1:0]          word
);
    logic [SIZE-1:0][WIDTH-1:0] words;

    assign words = bus;

    // Guard the index so an unused select code yields 0 rather than X.
    always_comb begin
        word = '0;
        if (32'(sel) < SIZE)
            word = words[sel];
    end
endmodule

// File: rtl/mux_switch_reg.sv
// Registered bit mux + word switch sharing one select. Both paths are
// independent word_select instances; this level only adds the output flops.
module mux_switch_reg import cpu_pkg::*; #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mux_switch_reg_if.slave  bus
);
    logic                  y_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;

    word_select #(.SIZE(SIZE), .WIDTH(1)) u_mux (
        .bus  (bus.D),
        .sel  (bus.S),
        .word (y_nxt)
    );

    word_select #(.SIZE(SIZE), .WIDTH(DATA_WIDTH)) u_switch (
        .bus  (bus.data_in),
        .sel  (bus.S),
        .word (data_nxt)
    );

    // Output register; synchronous reset wins over any select.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.Y        <= 1'b0;
            bus.data_out <= '0;
        end else begin
            bus.Y        <= y_nxt;
            bus.data_out <= data_nxt;
        end
    end
endmodule

// File: tb/tb_mux_switch_reg.sv
// Directed + random bench for mux_switch_reg with SIZE=8, 2 and 3 instances.
module tb_mux_switch_reg;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mux_switch_reg_if #(.SIZE(8), .DATA_WIDTH(16)) if8 ();
    mux_switch_reg_if #(.SIZE(2), .DATA_WIDTH(16)) if2 ();
    mux_switch_reg_if #(.SIZE(3), .DATA_WIDTH(16)) if3 ();

    mux_switch_reg #(.SIZE(8), .DATA_WIDTH(16)) u8 (.clk(clk), .reset(reset), .bus(if8));
    mux_switch_reg #(.SIZE(2), .DATA_WIDTH(16)) u2 (.clk(clk), .reset(reset), .bus(if2));
    mux_switch_reg #(.SIZE(3), .DATA_WIDTH(16)) u3 (.clk(clk), .reset(reset), .bus(if3));

    // Word contents per instance; packed onto data_in each cycle.
    logic [15:0] w8 [8];
    logic [15:0] w2 [2];
    logic [15:0] w3 [3];

    // Expected outputs after the pending edge, and the ones currently due.
    logic        ey8, ey2, ey3, py8, py2, py3;
    logic [15:0] ed8, ed2, ed3, pd8, pd2, pd3;
    bit          have_prev = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the selected element is the S-th entry if S is a valid
    // index, else zero; reset forces zero. Applied one edge later.
    task automatic cycle(input string tag);
        int s8, s2, s3;
        for (int i = 0; i < 8; i++) if8.data_in[i*16 +: 16] = w8[i];
        for (int i = 0; i < 2; i++) if2.data_in[i*16 +: 16] = w2[i];
        for (int i = 0; i < 3; i++) if3.data_in[i*16 +: 16] = w3[i];
        s8 = int'(if8.S); s2 = int'(if2.S); s3 = int'(if3.S);
        ey8 = 1'b0; ey2 = 1'b0; ey3 = 1'b0;
        ed8 = 16'h0; ed2 = 16'h0; ed3 = 16'h0;
        if (!reset) begin
            if (s8 < 8) begin ey8 = 1'((int'(if8.D) >> s8) & 1); ed8 = w8[s8]; end
            if (s2 < 2) begin ey2 = 1'((int'(if2.D) >> s2) & 1); ed2 = w2[s2]; end
            if (s3 < 3) begin ey3 = 1'((int'(if3.D) >> s3) & 1); ed3 = w3[s3]; end
        end
        // Just before the edge the outputs must still hold the old results.
        #3;
        if (have_prev) begin
            chk({tag, "/hold_y8"},  16'(if8.Y),  16'(py8));
            chk({tag, "/hold_d8"},  if8.data_out, pd8);
            chk({tag, "/hold_y3"},  16'(if3.Y),  16'(py3));
            chk({tag, "/hold_d3"},  if3.data_out, pd3);
        end
        @(posedge clk);
        #1;
        chk({tag, "/y8"}, 16'(if8.Y), 16'(ey8));
        chk({tag, "/d8"}, if8.data_out, ed8);
        chk({tag, "/y2"}, 16'(if2.Y), 16'(ey2));
        chk({tag, "/d2"}, if2.data_out, ed2);
        chk({tag, "/y3"}, 16'(if3.Y), 16'(ey3));
        chk({tag, "/d3"}, if3.data_out, ed3);
        py8 = ey8; py2 = ey2; py3 = ey3;
        pd8 = ed8; pd2 = ed2; pd3 = ed3;
        have_prev = 1;
    endtask

    initial begin
        // Reset held for two edges with live-looking inputs.
        reset = 1'b1;
        if8.S = 3'd3; if8.D = 8'hFF;
        if2.S = 1'b1; if2.D = 2'b11;
        if3.S = 2'd2; if3.D = 3'b111;
        for (int i = 0; i < 8; i++) w8[i] = 16'($urandom);
        for (int i = 0; i < 2; i++) w2[i] = 16'($urandom) | 16'h1;
        for (int i = 0; i < 3; i++) w3[i] = 16'($urandom) | 16'h1;
        @(posedge clk); #1;
        cycle("reset0");
        cycle("reset1");

        // Word sweep; first edge after release loads word 0.
        reset = 1'b0;
        for (int i = 0; i < 7; i++) w8[i] = 16'((i + 1) * 16'h0110);
        w8[7] = 16'h0108;
        for (int s = 0; s < 8; s++) begin
            if8.S = 3'(s);
            cycle("sweep");
        end

        // One-hot and inverted one-hot bit sweep.
        for (int s = 0; s < 8; s++) begin
            if8.S = 3'(s);
            if8.D = 8'(1 << s);
            cycle("onehot");
            if8.D = ~8'(1 << s);
            cycle("onecold");
        end

        // Two-input and out-of-range select on the three-input instance.
        if2.D = 2'b10;
        if2.S = 1'b0; cycle("size2_s0");
        if2.S = 1'b1; cycle("size2_s1");
        if3.D = 3'b111; if3.S = 2'd3; cycle("size3_oor");

        // Latency of a select change, then reset priority over S=7.
        if8.S = 3'd2; cycle("lat_s2");
        if8.S = 3'd5; cycle("lat_s5");
        reset = 1'b1; if8.S = 3'd7; cycle("rst_prio");
        reset = 1'b0; cycle("rst_release");

        // Toggle only the selected D bit; word output must not move.
        if8.S = 3'd4; if8.D = 8'h00;
        for (int k = 0; k < 6; k++) begin
            if8.D[4] = ~if8.D[4];
            cycle("indep");
        end

        // Random traffic with occasional resets.
        for (int k = 0; k < 60; k++) begin
            reset = ($urandom_range(9) == 0);
            if8.S = 3'($urandom); if8.D = 8'($urandom);
            if2.S = 1'($urandom); if2.D = 2'($urandom);
            if3.S = 2'($urandom_range(3)); if3.D = 3'($urandom);
            for (int i = 0; i < 8; i++) w8[i] = 16'($urandom);
            for (int i = 0; i < 2; i++) w2[i] = 16'($urandom);
            for (int i = 0; i < 3; i++) w3[i] = 16'($urandom);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
